// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 binary32 divider (restoring radix-2, one quotient bit per cycle)
// Ports:
//   clk, rst (async active-high)     clock and reset
//   start                            request, sampled only in IDLE
//   fp_X, fp_Y [31:0]                dividend, divisor (binary32, subnormals flushed to zero)
//   r_mode [2:0]                     000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   busy, done                       busy while an operation runs, done pulses when fp_Z is valid
//   fp_Z [31:0], ovrf, udrf, dvz     quotient and flags, held until the next accepted start
// Option: define FP_DIV_EARLY_OUT_EN to let special-case operands skip the DIVIDE phase.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        dvz
);
    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
    state_t      state;
    logic [31:0] x, y;
    logic [2:0]  rm;
    logic [23:0] my;
    logic [24:0] rem;
    logic [26:0] q;
    logic [4:0]  cnt;
    logic        sgn, zx, zy, ix, iy, nx, ny, special, spc_dvz, ge;
    logic [31:0] spc_z, rnd_z;
    logic        hi, g, st, inc, ovf, unf;
    logic [22:0] frac;
    logic [23:0] sum;
    logic signed [9:0] exp0, exp_r;

    assign sgn     = x[31] ^ y[31];
    assign zx      = x[30:23] == 8'd0;
    assign zy      = y[30:23] == 8'd0;
    assign ix      = (&x[30:23]) & ~(|x[22:0]);
    assign iy      = (&y[30:23]) & ~(|y[22:0]);
    assign nx      = (&x[30:23]) & (|x[22:0]);
    assign ny      = (&y[30:23]) & (|y[22:0]);
    assign special = nx | ny | ix | iy | zx | zy;
    assign spc_z   = (nx | ny | (ix & iy) | (zx & zy)) ? 32'h7FC00000 :
                     ix ? {sgn, 8'hFF, 23'd0} :
                     iy ? {sgn, 31'd0} :
                     zy ? {sgn, 8'hFF, 23'd0} : {sgn, 31'd0};
    assign spc_dvz = ~(nx | ny | ix | iy) & zy & ~zx;

    // Remainder stays below 2*mY, so a 25-bit register holds it across the shift.
    assign ge = rem >= {1'b0, my};

    // Quotient lies in [2^25, 2^27); q[26] selects which normalisation applies.
    assign hi    = q[26];
    assign frac  = hi ? q[25:3] : q[24:2];
    assign g     = hi ? q[2] : q[1];
    assign st    = (hi ? |q[1:0] : q[0]) | (|rem);
    assign exp0  = $signed({2'b0, x[30:23]}) - $signed({2'b0, y[30:23]}) + (hi ? 10'sd127 : 10'sd126);
    assign inc   = rm == 3'b001 ? 1'b0 :
                   rm == 3'b010 ? sgn & (g | st) :
                   rm == 3'b011 ? ~sgn & (g | st) :
                   rm == 3'b100 ? g : g & (st | frac[0]);
    // A carry out of the fraction leaves sum[22:0] zero and bumps the exponent.
    assign sum   = {1'b0, frac} + {23'd0, inc};
    assign exp_r = exp0 + $signed({9'd0, sum[23]});
    assign ovf   = exp_r >= 10'sd255;
    assign unf   = exp_r <= 10'sd0;
    assign rnd_z = ovf ? {sgn, 8'hFF, 23'd0} : unf ? {sgn, 31'd0} : {sgn, exp_r[7:0], sum[22:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            fp_Z  <= 32'd0;
            ovrf  <= 1'b0;
            udrf  <= 1'b0;
            dvz   <= 1'b0;
            x     <= 32'd0;
            y     <= 32'd0;
            rm    <= 3'd0;
            my    <= 24'd0;
            rem   <= 25'd0;
            q     <= 27'd0;
            cnt   <= 5'd0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    x     <= fp_X;
                    y     <= fp_Y;
                    rm    <= r_mode;
                    busy  <= 1'b1;
                    state <= UNPACK;
                end
                UNPACK: begin
                    my  <= {1'b1, y[22:0]};
                    rem <= {2'b01, x[22:0]};
                    q   <= 27'd0;
                    cnt <= 5'd0;
`ifdef FP_DIV_EARLY_OUT_EN
                    state <= special ? ROUND : DIVIDE;
`else
                    state <= DIVIDE;
`endif
                end
                DIVIDE: begin
                    q     <= {q[25:0], ge};
                    rem   <= (ge ? rem - {1'b0, my} : rem) << 1;
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd26 ? ROUND : DIVIDE;
                end
                ROUND: begin
                    fp_Z  <= special ? spc_z : rnd_z;
                    ovrf  <= ~special & ovf;
                    udrf  <= ~special & unf;
                    dvz   <= special & spc_dvz;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: randomized self-checking bench for fp_div_seq against an arithmetic reference model
module tb_fp_div_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] fp_X = 32'd0, fp_Y = 32'd0;
    logic [2:0]  r_mode = 3'd0;
    logic        busy, done, ovrf, udrf, dvz;
    logic [31:0] fp_Z;
    int          n_checks = 0, n_fail = 0;

`ifdef FP_DIV_EARLY_OUT_EN
    localparam int SPC_LAT = 2;
`else
    localparam int SPC_LAT = 29;
`endif

    fp_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
        .busy(busy), .done(done), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .dvz(dvz)
    );

    always #5 clk = ~clk;

    // Returns {special, dvz, udrf, ovrf, z}, built from the exact integer quotient.
    function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        int ex, ey, e;
        bit s, zx, zy, ix, iy, nx, ny, g, st, inc;
        longint num, my, q, rm, fr;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        zx = ex == 0;
        zy = ey == 0;
        ix = ex == 255 && x[22:0] == 0;
        iy = ey == 255 && y[22:0] == 0;
        nx = ex == 255 && x[22:0] != 0;
        ny = ey == 255 && y[22:0] != 0;
        if (nx || ny || (ix && iy) || (zx && zy)) return {4'b1000, 32'h7FC00000};
        if (ix) return {4'b1000, s, 8'hFF, 23'd0};
        if (iy) return {4'b1000, s, 31'd0};
        if (zy) return {4'b1100, s, 8'hFF, 23'd0};
        if (zx) return {4'b1000, s, 31'd0};
        num = longint'({1'b1, x[22:0]}) << 26;
        my  = longint'({1'b1, y[22:0]});
        q   = num / my;
        rm  = num % my;
        if (q >= (64'sd1 << 26)) begin
            fr = (q >> 3) & 'h7FFFFF; g = ((q >> 2) & 1) != 0; st = (q & 3) != 0 || rm != 0; e = ex - ey + 127;
        end else begin
            fr = (q >> 2) & 'h7FFFFF; g = ((q >> 1) & 1) != 0; st = (q & 1) != 0 || rm != 0; e = ex - ey + 126;
        end
        case (m)
            3'd1:    inc = 0;
            3'd2:    inc = s && (g || st);
            3'd3:    inc = !s && (g || st);
            3'd4:    inc = g;
            default: inc = g && (st || (fr & 1) != 0);
        endcase
        fr = fr + longint'(inc);
        if (fr == (64'sd1 << 23)) begin
            fr = 0;
            e  = e + 1;
        end
        if (e >= 255) return {4'b0001, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0010, s, 31'd0};
        return {4'b0000, s, 8'(e), 23'(fr)};
    endfunction

    // ef = {dvz, udrf, ovrf}
    task automatic check_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                            input logic [31:0] ez, input logic [2:0] ef, input int elat);
        int lat;
        @(negedge clk);
        fp_X = x; fp_Y = y; r_mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fp_X = $urandom; fp_Y = $urandom; r_mode = 3'($urandom);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy after start got %b exp 1", name, busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== elat) begin n_fail++; $display("FAIL %s latency got %0d exp %0d (x=%h y=%h)", name, lat, elat, x, y); end
        n_checks++;
        if (fp_Z !== ez) begin n_fail++; $display("FAIL %s fp_Z got %h exp %h (x=%h y=%h m=%0d)", name, fp_Z, ez, x, y, m); end
        n_checks++;
        if ({dvz, udrf, ovrf} !== ef) begin n_fail++; $display("FAIL %s flags dvz/udrf/ovrf got %b exp %b (x=%h y=%h)", name, {dvz, udrf, ovrf}, ef, x, y); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy at done got %b exp 0", name, busy); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || fp_Z !== ez) begin n_fail++; $display("FAIL %s after done got done=%b fp_Z=%h exp done=0 fp_Z=%h", name, done, fp_Z, ez); end
    endtask

    task automatic check_ref(input string name, input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        logic [35:0] r;
        r = ref_div(x, y, m);
        check_op(name, x, y, m, r[31:0], r[34:32], r[35] ? SPC_LAT : 29);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, fp_Z, ovrf, udrf, dvz} !== 37'd0) begin
            n_fail++; $display("FAIL reset outputs got busy=%b done=%b fp_Z=%h o=%b u=%b d=%b exp all 0", busy, done, fp_Z, ovrf, udrf, dvz);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        check_op("six_div_three", 32'h40C00000, 32'h40400000, 3'b000, 32'h40000000, 3'b000, 29);
        check_op("third_rne", 32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 3'b000, 29);
        check_op("third_rtz", 32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 3'b000, 29);
        check_op("neg_third_rdn", 32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 3'b000, 29);
        check_op("neg_third_rup", 32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 3'b000, 29);
        check_op("third_rmm", 32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 3'b000, 29);
        check_op("third_code7", 32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 3'b000, 29);
        check_op("div_by_zero", 32'hBF800000, 32'h00000000, 3'b000, 32'hFF800000, 3'b100, SPC_LAT);
        check_op("overflow", 32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 3'b001, 29);
        check_op("overflow_rtz", 32'h7F000000, 32'h3E800000, 3'b001, 32'h7F800000, 3'b001, 29);
        check_op("underflow", 32'h00800000, 32'h7F000000, 3'b000, 32'h00000000, 3'b010, 29);
        check_op("nan_x", 32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 3'b000, SPC_LAT);
        check_op("inf_inf", 32'hFF800000, 32'h7F800000, 3'b000, 32'h7FC00000, 3'b000, SPC_LAT);
        check_op("zero_zero", 32'h80000000, 32'h00000000, 3'b000, 32'h7FC00000, 3'b000, SPC_LAT);
        check_op("inf_by_zero", 32'h7F800000, 32'h00000000, 3'b000, 32'h7F800000, 3'b000, SPC_LAT);
        check_op("one_by_neg_inf", 32'h3F800000, 32'hFF800000, 3'b000, 32'h80000000, 3'b000, SPC_LAT);
        check_op("neg_zero_by_two", 32'h80000000, 32'h40000000, 3'b000, 32'h80000000, 3'b000, SPC_LAT);
        check_op("subnormal_x", 32'h00000001, 32'hBF800000, 3'b000, 32'h80000000, 3'b000, SPC_LAT);
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        int k;
        for (int i = 0; i < 60; i++) begin
            x = $urandom; y = $urandom; k = $urandom_range(0, 9);
            if (k < 5) begin
                x[30:23] = 8'($urandom_range(100, 150)); y[30:23] = 8'($urandom_range(100, 150));
            end else if (k == 5) x[30:23] = 8'hFF;
            else if (k == 6) y[30:23] = 8'h00;
            else if (k == 7) begin
                x[30:23] = 8'($urandom_range(250, 254)); y[30:23] = 8'($urandom_range(1, 5));
            end else if (k == 8) begin
                x[30:23] = 8'($urandom_range(1, 5)); y[30:23] = 8'($urandom_range(250, 254));
            end
            check_ref("random", x, y, 3'($urandom_range(0, 7)));
        end
    endtask

    // start held high throughout: ignored while busy and in the done cycle; operand changes ignored too.
    task automatic test_start_held;
        logic [35:0] r;
        int lat;
        r = ref_div(32'h41200000, 32'h40E00000, 3'b000);
        @(negedge clk);
        fp_X = 32'h41200000; fp_Y = 32'h40E00000; r_mode = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        fp_X = 32'h3F800000; fp_Y = 32'h40400000; r_mode = 3'b011;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== 29 || fp_Z !== r[31:0]) begin n_fail++; $display("FAIL start_held result got lat=%0d fp_Z=%h exp lat=29 fp_Z=%h", lat, fp_Z, r[31:0]); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_cycle busy got %b exp 0", busy); end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        bit seen;
        int lat;
        check_op("pre_abort", 32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 3'b000, 29);
        @(negedge clk);
        fp_X = 32'h40C00000; fp_Y = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        fp_X = 32'h7F000000; fp_Y = 32'h3E800000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort busy before reset got %b exp 1", busy); end
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, fp_Z, ovrf, udrf, dvz} !== 37'd0) begin
            n_fail++; $display("FAIL abort reset outputs got busy=%b done=%b fp_Z=%h o=%b u=%b d=%b exp all 0", busy, done, fp_Z, ovrf, udrf, dvz);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (35) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen = 1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort no_done got activity=1 exp 0"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; fp_X = 32'h40C00000; fp_Y = 32'h40400000; r_mode = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL first_edge_after_reset busy got %b exp 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== 29 || fp_Z !== 32'h40000000 || {dvz, udrf, ovrf} !== 3'b000) begin
            n_fail++; $display("FAIL after_reset op got lat=%0d fp_Z=%h flags=%b exp 29 40000000 000", lat, fp_Z, {dvz, udrf, ovrf});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_start_held;
        test_reset_abort;
        check_op("back_to_back", 32'hC1200000, 32'h3F000000, 3'b000, 32'hC1A00000, 3'b000, 29);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
